// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM encodings and the
// register-offset decode used by both the slave and the master.
package axi4lite_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // Word offset of addr from base, computed on addr_w-2 bits so that an
  // address below base wraps to a large value and falls out of range.
  function automatic logic [63:0] decode_offset(input logic [63:0] addr,
                                                input logic [63:0] base,
                                                input int unsigned addr_w);
    logic [63:0] mask;
    mask = (64'd1 << (addr_w - 2)) - 64'd1;
    return ((addr >> 2) - (base >> 2)) & mask;
  endfunction

  function automatic logic decode_hit(input logic [63:0] off,
                                     input int unsigned num_regs);
    return off < 64'(num_regs);
  endfunction

endpackage

// File: rtl/axi4lite_reg_bank.sv
// Register storage with a byte-strobed write port, a combinational read
// mux, a registered per-register write strobe and flattened contents.
module axi4lite_reg_bank
  import axi4lite_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_we,
  input  logic [IDX_W-1:0]           i_widx,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic [DATA_W/8-1:0]        i_wstrb,
  input  logic [IDX_W-1:0]           i_ridx,
  output logic [DATA_W-1:0]          o_rdata,
  output logic [NUM_REGS*DATA_W-1:0] o_reg_q,
  output logic [NUM_REGS-1:0]        o_wr_stb
);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0]             r_stb;

  // Commit selected bytes and pulse the strobe of the written register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '0;
      r_stb  <= '0;
    end else begin
      r_stb <= '0;
      if (i_we) begin
        r_stb[i_widx] <= 1'b1;
        for (int b = 0; b < DATA_W/8; b++) begin
          if (i_wstrb[b]) r_regs[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read mux; an index beyond the bank reads as zero.
  always_comb begin
    o_rdata = '0;
    if (int'(i_ridx) < NUM_REGS) o_rdata = r_regs[i_ridx];
  end

  assign o_reg_q  = r_regs;
  assign o_wr_stb = r_stb;

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder for a bank of 32-bit registers. Independent write
// and read FSMs, one outstanding transaction each, SLVERR outside the bank.
module axi4lite_slave_regs
  import axi4lite_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_REGS  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [31:0]                WDATA,
  input  logic [3:0]                 WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [31:0]                RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_REGS*32-1:0]     reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_stb
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  wstate_t             r_wstate;
  rstate_t             r_rstate;
  logic                r_aw_got, r_w_got;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_awready, r_wready, r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_arready, r_rvalid;
  logic [1:0]          r_rresp;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_aw_hs, w_w_hs, w_ar_hs;
  logic [63:0]         w_wr_off, w_rd_off;
  logic                w_wr_hit, w_rd_hit, w_we;
  logic [IDX_W-1:0]    w_wr_idx, w_rd_idx;
  logic [DATA_W-1:0]   w_bank_rdata;

  assign w_aw_hs  = AWVALID && r_awready;
  assign w_w_hs   = WVALID && r_wready;
  assign w_ar_hs  = ARVALID && r_arready;

  assign w_wr_off = decode_offset(64'(r_awaddr), 64'(BASE_ADDR), ADDR_W);
  assign w_rd_off = decode_offset(64'(ARADDR), 64'(BASE_ADDR), ADDR_W);
  assign w_wr_hit = decode_hit(w_wr_off, NUM_REGS);
  assign w_rd_hit = decode_hit(w_rd_off, NUM_REGS);
  assign w_wr_idx = w_wr_off[IDX_W-1:0];
  assign w_rd_idx = w_rd_off[IDX_W-1:0];
  assign w_we     = (r_wstate == W_EXEC) && w_wr_hit;

  // Hold the captured write address and data until the commit step.
  always_ff @(posedge ACLK) begin
    if (w_aw_hs) r_awaddr <= AWADDR;
    if (w_w_hs) begin
      r_wdata <= WDATA;
      r_wstrb <= WSTRB;
    end
  end

  // Write FSM: collect AW and W in any order, commit for one cycle, then
  // hold the B response until the master accepts it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_got  <= 1'b1;
            r_awready <= 1'b0;
          end else begin
            r_awready <= !r_aw_got;
          end
          if (w_w_hs) begin
            r_w_got  <= 1'b1;
            r_wready <= 1'b0;
          end else begin
            r_wready <= !r_w_got;
          end
          if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) r_wstate <= W_EXEC;
        end
        W_EXEC: begin
          r_bvalid <= 1'b1;
          r_bresp  <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
          r_wstate <= W_RESP;
        end
        W_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: register data on the AR handshake and hold it until RREADY.
  // The bank is sampled before any same-edge commit, so a colliding read
  // returns the pre-write value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_hit ? w_bank_rdata : '0;
            r_rresp   <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  axi4lite_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk      (ACLK),
    .rst      (ARESET),
    .i_we     (w_we),
    .i_widx   (w_wr_idx),
    .i_wdata  (r_wdata),
    .i_wstrb  (r_wstrb),
    .i_ridx   (w_rd_idx),
    .o_rdata  (w_bank_rdata),
    .o_reg_q  (reg_q),
    .o_wr_stb (reg_wr_stb)
  );

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RRESP   = r_rresp;
  assign RDATA   = r_rdata;

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs: a vector table of single
// transactions plus hand-timed sequences for the multi-cycle cases.
module tb_axi4lite_slave_regs;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [31:0]  AWADDR = '0;
  logic         AWVALID = 1'b0;
  logic         AWREADY;
  logic [31:0]  WDATA = '0;
  logic [3:0]   WSTRB = '0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY = 1'b0;
  logic [31:0]  ARADDR = '0;
  logic         ARVALID = 1'b0;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY = 1'b0;
  logic [255:0] reg_q;
  logic [7:0]   reg_wr_stb;

  int checks = 0;
  int errors = 0;

  axi4lite_slave_regs #(
    .ADDR_W    (32),
    .NUM_REGS  (8),
    .BASE_ADDR (32'h1000_0000)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .AWADDR     (AWADDR),
    .AWVALID    (AWVALID),
    .AWREADY    (AWREADY),
    .WDATA      (WDATA),
    .WSTRB      (WSTRB),
    .WVALID     (WVALID),
    .WREADY     (WREADY),
    .BRESP      (BRESP),
    .BVALID     (BVALID),
    .BREADY     (BREADY),
    .ARADDR     (ARADDR),
    .ARVALID    (ARVALID),
    .ARREADY    (ARREADY),
    .RDATA      (RDATA),
    .RRESP      (RRESP),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .reg_q      (reg_q),
    .reg_wr_stb (reg_wr_stb)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_stb;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue AW and W together; called at a negedge, returns at the negedge
  // after the B handshake. stb_seen ORs every strobe observed meanwhile.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [7:0] stb_seen);
    bit aw_p, w_p, done;
    int n;
    AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1; BREADY = 1'b1;
    resp = 2'b11; stb_seen = '0; done = 0; n = 0;
    while (!done && n < 40) begin
      aw_p = AWVALID && AWREADY;
      w_p  = WVALID && WREADY;
      stb_seen |= reg_wr_stb;
      if (BVALID) begin
        resp = BRESP;
        done = 1;
      end
      @(negedge ACLK);
      n++;
      if (aw_p) AWVALID = 1'b0;
      if (w_p) WVALID = 1'b0;
    end
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL write_timeout: got no BVALID expected BVALID within 40 cycles");
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
    bit ar_p, done;
    int n;
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    data = 32'hxxxx_xxxx; resp = 2'b11; done = 0; n = 0;
    while (!done && n < 40) begin
      ar_p = ARVALID && ARREADY;
      if (RVALID) begin
        data = RDATA;
        resp = RRESP;
        done = 1;
      end
      @(negedge ACLK);
      n++;
      if (ar_p) ARVALID = 1'b0;
    end
    ARVALID = 1'b0; RREADY = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL read_timeout: got no RVALID expected RVALID within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   resp;
    logic [31:0]  rd;
    logic [7:0]   stb;
    logic [255:0] snap;

    vecs[0]  = '{"wr_reg0",      1, 32'h1000_0000, 32'h1122_3344, 4'hF, 2'b00, 32'h0,          8'h01};
    vecs[1]  = '{"wr_reg7",      1, 32'h1000_001C, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0,          8'h80};
    vecs[2]  = '{"wr_oor_above", 1, 32'h1000_0020, 32'h0000_0099, 4'hF, 2'b10, 32'h0,          8'h00};
    vecs[3]  = '{"wr_oor_below", 1, 32'h0FFF_FFFC, 32'h7777_7777, 4'hF, 2'b10, 32'h0,          8'h00};
    vecs[4]  = '{"rd_reg1",      0, 32'h1000_0004, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 8'h00};
    vecs[5]  = '{"rd_reg0",      0, 32'h1000_0000, 32'h0,         4'h0, 2'b00, 32'h1122_3344, 8'h00};
    vecs[6]  = '{"rd_reg7_lsb",  0, 32'h1000_001E, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D, 8'h00};
    vecs[7]  = '{"rd_oor_above", 0, 32'h1000_0020, 32'h0,         4'h0, 2'b10, 32'h0,          8'h00};
    vecs[8]  = '{"rd_oor_below", 0, 32'h0FFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0,          8'h00};
    vecs[9]  = '{"wr_reg0_strb", 1, 32'h1000_0003, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0,          8'h01};
    vecs[10] = '{"rd_reg0_strb", 0, 32'h1000_0000, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD, 8'h00};
    vecs[11] = '{"wr_reg2_nostb",1, 32'h1000_0008, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0,          8'h04};
    vecs[12] = '{"rd_reg2",      0, 32'h1000_0008, 32'h0,         4'h0, 2'b00, 32'h0000_5678, 8'h00};

    // Reset state
    repeat (3) @(negedge ACLK);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_regq_zero", reg_q == '0, 1);
    chk("rst_stb", reg_wr_stb, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_wready", WREADY, 1);
    chk("post_rst_arready", ARREADY, 1);

    // Single write, AW and W in the same cycle
    AWADDR = 32'h1000_0004; AWVALID = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("sw_awready_drop", AWREADY, 0);
    chk("sw_wready_drop", WREADY, 0);
    chk("sw_bvalid_early", BVALID, 0);
    @(negedge ACLK);
    chk("sw_bvalid", BVALID, 1);
    chk("sw_bresp", BRESP, 2'b00);
    chk("sw_reg1", reg_q[63:32], 32'hDEAD_BEEF);
    chk("sw_stb", reg_wr_stb, 8'h02);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("sw_bvalid_clr", BVALID, 0);
    chk("sw_stb_clr", reg_wr_stb, 8'h00);
    chk("sw_awready_back", AWREADY, 1);
    chk("sw_wready_back", WREADY, 1);

    // W before AW with a partial strobe
    WDATA = 32'h1234_5678; WSTRB = 4'b0011; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    chk("wfirst_wready_drop", WREADY, 0);
    chk("wfirst_awready_held", AWREADY, 1);
    repeat (2) begin
      @(negedge ACLK);
      chk("wfirst_bvalid_wait", BVALID, 0);
    end
    AWADDR = 32'h1000_0008; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("wfirst_bvalid_capture_edge", BVALID, 0);
    @(negedge ACLK);
    chk("wfirst_bvalid", BVALID, 1);
    chk("wfirst_bresp", BRESP, 2'b00);
    chk("wfirst_reg2", reg_q[95:64], 32'h0000_5678);
    chk("wfirst_stb", reg_wr_stb, 8'h04);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        snap = reg_q;
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, stb);
        chk({vecs[i].name, "_bresp"}, resp, vecs[i].exp_resp);
        chk({vecs[i].name, "_stb"}, stb, vecs[i].exp_stb);
        if (vecs[i].exp_resp == 2'b10) chk({vecs[i].name, "_regq_kept"}, reg_q == snap, 1);
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        chk({vecs[i].name, "_rresp"}, resp, vecs[i].exp_resp);
        chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      end
    end

    // Read with RREADY held low
    chk("bp_arready_idle", ARREADY, 1);
    ARADDR = 32'h1000_0004; ARVALID = 1'b1; RREADY = 1'b0;
    @(negedge ACLK);
    ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_rvalid", RVALID, 1);
      chk("bp_rdata", RDATA, 32'hDEAD_BEEF);
      chk("bp_arready", ARREADY, 0);
      @(negedge ACLK);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    chk("bp_arready_back", ARREADY, 1);
    chk("bp_rvalid_clr", RVALID, 0);

    // Read/write collision on reg3
    axi_write(32'h1000_000C, 32'hAAAA_AAAA, 4'hF, resp, stb);
    chk("col_pre_bresp", resp, 2'b00);
    AWADDR = 32'h1000_000C; AWVALID = 1'b1; WDATA = 32'h5555_5555; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("col_arready", ARREADY, 1);
    ARADDR = 32'h1000_000C; ARVALID = 1'b1; RREADY = 1'b0;
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("col_rvalid", RVALID, 1);
    chk("col_rdata_old", RDATA, 32'hAAAA_AAAA);
    chk("col_bvalid", BVALID, 1);
    chk("col_reg3_new", reg_q[127:96], 32'h5555_5555);
    RREADY = 1'b1; BREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0; BREADY = 1'b0;
    axi_read(32'h1000_000C, rd, resp);
    chk("col_rdata_new", rd, 32'h5555_5555);

    // Reset while a B response is pending
    AWADDR = 32'h1000_0010; AWVALID = 1'b1; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF; WVALID = 1'b1;
    BREADY = 1'b0;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    chk("rw_bvalid", BVALID, 1);
    chk("rw_reg4", reg_q[159:128], 32'h0BAD_F00D);
    @(negedge ACLK);
    chk("rw_bvalid_held", BVALID, 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("rw_rst_bvalid", BVALID, 0);
    chk("rw_rst_awready", AWREADY, 0);
    chk("rw_rst_wready", WREADY, 0);
    chk("rw_rst_arready", ARREADY, 0);
    chk("rw_rst_reg4", reg_q[159:128], 32'h0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rw_awready_back", AWREADY, 1);
    chk("rw_wready_back", WREADY, 1);
    chk("rw_arready_back", ARREADY, 1);
    repeat (2) @(negedge ACLK);
    chk("rw_no_bvalid", BVALID, 0);
    axi_read(32'h1000_0010, rd, resp);
    chk("rw_reg4_read", rd, 32'h0);
    chk("rw_reg4_rresp", resp, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
